// File: rtl/cache_mem_responder.sv
// Line-organised memory responder serving the cache FSM with fixed latency.
// Optional read/write completion counters: define CACHE_MEM_STATS_EN.
package cache_mem_pkg;

   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
      logic         rw;
      logic         valid;
   } mem_req_type;

   typedef struct packed {
      logic [127:0] data;
      logic         ready;
   } mem_data_type;

endpackage

module cache_mem_responder
   import cache_mem_pkg::*;
#(
   parameter int LATENCY     = 4,
   parameter int DEPTH_LINES = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  mem_req_type  mem_req,
   output mem_data_type mem_data
`ifdef CACHE_MEM_STATS_EN
   ,
   output logic [31:0]  rd_cnt,
   output logic [31:0]  wr_cnt
`endif
);

   localparam int AW = $clog2(DEPTH_LINES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q;
   logic [7:0]      cnt_q;
   logic [AW-1:0]   idx_q;
   logic [127:0]    wdata_q;
   logic            rw_q;
   logic [127:0]    rdata_q;
   logic            ready_q;

   logic [127:0]    mem_q [DEPTH_LINES];
   logic [127:0]    line_rd;
   logic            commit;
   logic            mem_we;
   logic            unused_addr;

   function automatic logic [127:0] init_line(input logic [AW-1:0] i);
      logic [31:0] b;
      b = 32'(i) << 4;
      return {b | 32'hC, b | 32'h8, b | 32'h4, b};
   endfunction

   assign unused_addr = ^{mem_req.addr[3:0], mem_req.addr[31:4+AW]};

   assign commit  = (state_q == BUSY) && (cnt_q == 8'd0);
   assign mem_we  = commit && rw_q && !rst;

   // Lines are stored XOR'd with their address pattern, so a zero-filled
   // array reads back as the byte-address initial contents.
   assign line_rd = mem_q[idx_q] ^ init_line(idx_q);

   always_ff @(posedge clk) begin
      if (mem_we)
         mem_q[idx_q] <= wdata_q ^ init_line(idx_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         rw_q    <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         unique case (state_q)
            IDLE, RESP: begin
               if (mem_req.valid) begin
                  idx_q   <= mem_req.addr[4 +: AW];
                  wdata_q <= mem_req.data;
                  rw_q    <= mem_req.rw;
                  cnt_q   <= 8'(LATENCY - 1);
                  state_q <= BUSY;
               end else begin
                  state_q <= IDLE;
               end
            end
            BUSY: begin
               if (cnt_q == 8'd0) begin
                  rdata_q <= rw_q ? wdata_q : line_rd;
                  ready_q <= 1'b1;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_data.data  = rdata_q;
   assign mem_data.ready = ready_q;

`ifdef CACHE_MEM_STATS_EN
   logic [31:0] rd_cnt_q;
   logic [31:0] wr_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else if (commit) begin
         if (rw_q && wr_cnt_q != 32'hFFFF_FFFF)
            wr_cnt_q <= wr_cnt_q + 32'd1;
         if (!rw_q && rd_cnt_q != 32'hFFFF_FFFF)
            rd_cnt_q <= rd_cnt_q + 32'd1;
      end
   end

   assign rd_cnt = rd_cnt_q;
   assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder (LATENCY=4, DEPTH_LINES=1024).
module tb_cache_mem_responder;
   import cache_mem_pkg::*;

   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst;
   mem_req_type  req;
   mem_data_type rsp;
`ifdef CACHE_MEM_STATS_EN
   logic [31:0]  rd_cnt;
   logic [31:0]  wr_cnt;
`endif

   int chk = 0;
   int pas = 0;

   always #5 clk = ~clk;

   cache_mem_responder #(.LATENCY(LAT), .DEPTH_LINES(1024)) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_req  (req),
      .mem_data (rsp)
`ifdef CACHE_MEM_STATS_EN
      ,
      .rd_cnt   (rd_cnt),
      .wr_cnt   (wr_cnt)
`endif
   );

   function automatic logic [127:0] pat(input int unsigned line);
      logic [31:0] b;
      b = line << 4;
      return {b | 32'hC, b | 32'h8, b | 32'h4, b};
   endfunction

   // Called at a negedge; returns at the first negedge after capture.
   task automatic send(input logic [31:0] a, input logic [127:0] d,
                       input logic rw);
      req.addr  = a;
      req.data  = d;
      req.rw    = rw;
      req.valid = 1'b1;
      @(negedge clk);
      req.valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0;
      repeat (2) @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", rsp.ready);
      else pas++;
      chk++;
      if (rsp.data !== 128'h0) $display("FAIL rst_data: got %h want 0", rsp.data);
      else pas++;
      rst = 1'b0;
      @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b0) $display("FAIL post_rst_ready: got %b want 0", rsp.ready);
      else pas++;
   endtask

   task automatic test_read();
      int early;
      early = 0;
      send(32'h0000_0120, '0, 1'b0);
      for (int i = 1; i <= LAT; i++) begin
         if (rsp.ready !== 1'b0) early++;
         @(negedge clk);
      end
      chk++;
      if (early != 0) $display("FAIL read_early: got %0d early cycles want 0", early);
      else pas++;
      chk++;
      if (rsp.ready !== 1'b1) $display("FAIL read_ready: got %b want 1", rsp.ready);
      else pas++;
      chk++;
      if (rsp.data !== {32'h12C, 32'h128, 32'h124, 32'h120})
         $display("FAIL read_data: got %h want %h", rsp.data,
                  {32'h12C, 32'h128, 32'h124, 32'h120});
      else pas++;
      @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b0) $display("FAIL read_pulse: got %b want 0", rsp.ready);
      else pas++;
   endtask

   task automatic test_back_to_back();
      logic [127:0] d;
      int early;
      d = 128'hDEAD0123_4567_89AB_CDEF_0011_2233_BEEF;
      early = 0;
      send(32'h40, d, 1'b1);
      repeat (LAT) @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b1 || rsp.data !== d)
         $display("FAIL b2b_wr_resp: got %b/%h want 1/%h", rsp.ready, rsp.data, d);
      else pas++;
      send(32'h40, '0, 1'b0);
      for (int i = 1; i <= LAT; i++) begin
         if (rsp.ready !== 1'b0) early++;
         @(negedge clk);
      end
      chk++;
      if (early != 0) $display("FAIL b2b_early: got %0d early cycles want 0", early);
      else pas++;
      chk++;
      if (rsp.ready !== 1'b1) $display("FAIL b2b_rd_ready: got %b want 1", rsp.ready);
      else pas++;
      chk++;
      if (rsp.data !== d) $display("FAIL b2b_rd_data: got %h want %h", rsp.data, d);
      else pas++;
      @(negedge clk);
   endtask

   task automatic test_wrap();
      send(32'h0001_0010, '0, 1'b0);
      repeat (LAT) @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b1 || rsp.data !== pat(1))
         $display("FAIL wrap: got %b/%h want 1/%h", rsp.ready, rsp.data, pat(1));
      else pas++;
      chk++;
      if (rsp.data[31:0] !== 32'h10)
         $display("FAIL wrap_w0: got %h want 00000010", rsp.data[31:0]);
      else pas++;
      @(negedge clk);
   endtask

   task automatic test_reset_busy();
      send(32'h80, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b0 || rsp.data !== 128'h0)
         $display("FAIL rstbusy_in_rst: got %b/%h want 0/0", rsp.ready, rsp.data);
      else pas++;
      rst = 1'b0;
      @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b0) $display("FAIL rstbusy_after: got %b want 0", rsp.ready);
      else pas++;
      repeat (LAT + 1) @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b0) $display("FAIL rstbusy_idle: got %b want 0", rsp.ready);
      else pas++;
      send(32'h80, '0, 1'b0);
      repeat (LAT) @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b1 || rsp.data !== pat(8))
         $display("FAIL rstbusy_rd: got %b/%h want 1/%h", rsp.ready, rsp.data, pat(8));
      else pas++;
      @(negedge clk);
   endtask

   task automatic test_busy_change();
      send(32'h200, '0, 1'b0);
      req.addr  = 32'h300;
      req.data  = {4{32'hA5A5_5A5A}};
      req.rw    = 1'b1;
      req.valid = 1'b1;
      repeat (LAT - 1) @(negedge clk);
      req.valid = 1'b0;
      @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b1 || rsp.data !== pat(32'h20))
         $display("FAIL busychg: got %b/%h want 1/%h", rsp.ready, rsp.data, pat(32'h20));
      else pas++;
      @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b0) $display("FAIL busychg_pulse: got %b want 0", rsp.ready);
      else pas++;
      send(32'h300, '0, 1'b0);
      repeat (LAT) @(negedge clk);
      chk++;
      if (rsp.data !== pat(32'h30))
         $display("FAIL busychg_nowr: got %h want %h", rsp.data, pat(32'h30));
      else pas++;
      @(negedge clk);
   endtask

   task automatic test_continuous();
      int early;
      early = 0;
      req.addr  = 32'h30;
      req.rw    = 1'b0;
      req.valid = 1'b1;
      @(negedge clk);
      repeat (LAT) @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b1 || rsp.data !== pat(3))
         $display("FAIL cont_first: got %b/%h want 1/%h", rsp.ready, rsp.data, pat(3));
      else pas++;
      for (int i = 1; i <= LAT; i++) begin
         @(negedge clk);
         if (rsp.ready !== 1'b0) early++;
      end
      @(negedge clk);
      chk++;
      if (early != 0 || rsp.ready !== 1'b1)
         $display("FAIL cont_second: got early=%0d ready=%b want 0/1", early, rsp.ready);
      else pas++;
      req.valid = 1'b0;
      repeat (2) @(negedge clk);
      chk++;
      if (rsp.ready !== 1'b0) $display("FAIL cont_stop: got %b want 0", rsp.ready);
      else pas++;
   endtask

`ifdef CACHE_MEM_STATS_EN
   task automatic xact(input logic [31:0] a, input logic rw);
      send(a, {4{a}}, rw);
      repeat (LAT + 1) @(negedge clk);
   endtask

   task automatic test_stats();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      xact(32'h10, 1'b0);
      xact(32'h500, 1'b1);
      xact(32'h20, 1'b0);
      xact(32'h510, 1'b1);
      xact(32'h500, 1'b0);
      chk++;
      if (rd_cnt !== 32'd3) $display("FAIL stats_rd: got %0d want 3", rd_cnt);
      else pas++;
      chk++;
      if (wr_cnt !== 32'd2) $display("FAIL stats_wr: got %0d want 2", wr_cnt);
      else pas++;
      force dut.rd_cnt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.rd_cnt_q;
      xact(32'h10, 1'b0);
      chk++;
      if (rd_cnt !== 32'hFFFF_FFFF)
         $display("FAIL stats_sat: got %h want ffffffff", rd_cnt);
      else pas++;
      chk++;
      if (wr_cnt !== 32'd2) $display("FAIL stats_wr_hold: got %0d want 2", wr_cnt);
      else pas++;
   endtask
`endif

   initial begin
      test_reset();
      test_read();
      test_back_to_back();
      test_wrap();
      test_reset_busy();
      test_busy_change();
      test_continuous();
`ifdef CACHE_MEM_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", pas, chk);
      $finish;
   end

endmodule
